// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the 16x oversampled UART receive path.
//   rx_state_e      : receiver FSM states
//   OS_RATE/TICK_W  : oversampling ratio and tick counter width
//   SAMPLE_A/B/C    : tick indices of the three mid-bit samples
//   BIT_END         : tick index on which a bit period closes
//   PCFG_*          : bit positions inside parity_cfg
//   majority3       : 2-of-3 vote used for the bit decision
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_STOP2     = 3'd5,
      ST_WAIT_HIGH = 3'd6
   } rx_state_e;

   localparam int OS_RATE = 16;
   localparam int TICK_W  = $clog2(OS_RATE);

   localparam logic [TICK_W-1:0] SAMPLE_A = 4'd7;
   localparam logic [TICK_W-1:0] SAMPLE_B = 4'd8;
   localparam logic [TICK_W-1:0] SAMPLE_C = 4'd9;
   localparam logic [TICK_W-1:0] BIT_END  = 4'd15;

   localparam int PCFG_EN       = 0;
   localparam int PCFG_ODD      = 1;
   localparam int PCFG_STICK    = 2;
   localparam int PCFG_TWO_STOP = 3;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_bit_sampler
// Line front end of the receiver: synchronises ser_in, detects falling edges,
// counts baud ticks within a bit and votes on three mid-bit samples.
//   clock, rstn    : system clock, async active-low reset
//   baud_tick      : one-clock pulse, 16 per bit
//   ser_in         : raw asynchronous serial line
//   tick_clr       : restart the bit timing (start edge accepted)
//   s_in           : synchronised line
//   falling_edge   : s_in is 0 and was 1 on the previous clock
//   bit_valid      : decision strobe (tick 9)
//   bit_end        : last tick of the bit period (tick 15)
//   bit_value      : majority of the samples on ticks 7, 8, 9
// -----------------------------------------------------------------------------
module uart_bit_sampler
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic rstn,
   input  logic baud_tick,
   input  logic ser_in,
   input  logic tick_clr,
   output logic s_in,
   output logic falling_edge,
   output logic bit_valid,
   output logic bit_end,
   output logic bit_value
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
   logic                   samp_a_q, samp_a_d;
   logic                   samp_b_q, samp_b_d;

   assign s_in         = sync_q[SYNC_STAGES-1];
   assign falling_edge = prev_q & ~s_in;
   assign bit_valid    = baud_tick && (tick_cnt_q == SAMPLE_C);
   assign bit_end      = baud_tick && (tick_cnt_q == BIT_END);
   // Third sample is the live line on the tick-9 clock, so the vote is ready
   // on the same clock that bit_valid fires.
   assign bit_value    = majority3(samp_a_q, samp_b_q, s_in);

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], ser_in};
      prev_d     = s_in;
      tick_cnt_d = tick_cnt_q;
      samp_a_d   = samp_a_q;
      samp_b_d   = samp_b_q;
      if (tick_clr) begin
         tick_cnt_d = '0;
      end else if (baud_tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
      if (baud_tick && (tick_cnt_q == SAMPLE_A)) samp_a_d = s_in;
      if (baud_tick && (tick_cnt_q == SAMPLE_B)) samp_b_d = s_in;
   end

   // Line flops reset high so releasing reset never looks like a start edge.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         sync_q     <= '1;
         prev_q     <= 1'b1;
         tick_cnt_q <= '0;
         samp_a_q   <= 1'b1;
         samp_b_q   <= 1'b1;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         tick_cnt_q <= tick_cnt_d;
         samp_a_q   <= samp_a_d;
         samp_b_q   <= samp_b_d;
      end
   end

endmodule

// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// 16x oversampled UART receiver (start, DATA_BITS LSB first, optional parity,
// one or two stop bits). Frame FSM and shift register; line handling lives in
// uart_bit_sampler.
//   clock, rstn      : system clock, async active-low reset
//   baud_tick        : one-clock pulse, 16 per bit
//   parity_cfg[3:0]  : [0] parity en, [1] odd, [2] stick, [3] two stop bits;
//                      captured at the start edge
//   ser_in           : serial line, idle high
//   rx_data          : last received payload
//   rx_new_data      : one-clock strobe, rx_data and error flags valid
//   rx_parity_error  : parity mismatch on the strobed frame
//   rx_end_error     : a stop bit sampled low on the strobed frame
//   rx_begin_error   : one-clock pulse, false start rejected
//   rx_busy          : receiver not idle
// -----------------------------------------------------------------------------
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clock,
   input  logic                 rstn,
   input  logic                 baud_tick,
   input  logic [3:0]           parity_cfg,
   input  logic                 ser_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_new_data,
   output logic                 rx_parity_error,
   output logic                 rx_end_error,
   output logic                 rx_begin_error,
   output logic                 rx_busy
);

   rx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [3:0]           cfg_q, cfg_d;
   logic                 par_err_q, par_err_d;
   logic                 stop_err_q, stop_err_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_new_q, rx_new_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_eerr_q, rx_eerr_d;
   logic                 rx_berr_q, rx_berr_d;

   logic s_in, falling_edge, bit_valid, bit_end, bit_value, tick_clr;

   uart_bit_sampler #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clock        (clock),
      .rstn         (rstn),
      .baud_tick    (baud_tick),
      .ser_in       (ser_in),
      .tick_clr     (tick_clr),
      .s_in         (s_in),
      .falling_edge (falling_edge),
      .bit_valid    (bit_valid),
      .bit_end      (bit_end),
      .bit_value    (bit_value)
   );

   function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic [3:0] cfg);
      if (cfg[PCFG_STICK]) return cfg[PCFG_ODD];
      return (^d) ^ cfg[PCFG_ODD];
   endfunction

   assign rx_data         = rx_data_q;
   assign rx_new_data     = rx_new_q;
   assign rx_parity_error = rx_perr_q;
   assign rx_end_error    = rx_eerr_q;
   assign rx_begin_error  = rx_berr_q;
   assign rx_busy         = (state_q != ST_IDLE);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      cfg_d      = cfg_q;
      par_err_d  = par_err_q;
      stop_err_d = stop_err_q;
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_eerr_d  = rx_eerr_q;
      rx_new_d   = 1'b0;
      rx_berr_d  = 1'b0;
      tick_clr   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (falling_edge) begin
               tick_clr   = 1'b1;
               cfg_d      = parity_cfg;
               par_err_d  = 1'b0;
               stop_err_d = 1'b0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (bit_valid && bit_value) begin
               rx_berr_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (bit_end) begin
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_valid) begin
               shift_d   = {bit_value, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (bit_end && (bit_cnt_q == 4'(DATA_BITS))) begin
               state_d = cfg_q[PCFG_EN] ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_valid) par_err_d = bit_value ^ exp_parity(shift_q, cfg_q);
            if (bit_end)   state_d   = ST_STOP;
         end
         ST_STOP: begin
            if (bit_valid) begin
               if (cfg_q[PCFG_TWO_STOP]) begin
                  stop_err_d = ~bit_value;
               end else begin
                  rx_data_d = shift_q;
                  rx_perr_d = par_err_q;
                  rx_eerr_d = ~bit_value;
                  rx_new_d  = 1'b1;
                  // Leave at mid stop bit so the next start edge is never missed.
                  state_d   = bit_value ? ST_IDLE : ST_WAIT_HIGH;
               end
            end
            if (bit_end) state_d = ST_STOP2;
         end
         ST_STOP2: begin
            if (bit_valid) begin
               rx_data_d = shift_q;
               rx_perr_d = par_err_q;
               rx_eerr_d = stop_err_q | ~bit_value;
               rx_new_d  = 1'b1;
               state_d   = bit_value ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            // A line held low (break) must return high before a new start counts.
            if (s_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         cfg_q      <= '0;
         par_err_q  <= 1'b0;
         stop_err_q <= 1'b0;
         rx_data_q  <= '0;
         rx_new_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_eerr_q  <= 1'b0;
         rx_berr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         cfg_q      <= cfg_d;
         par_err_q  <= par_err_d;
         stop_err_q <= stop_err_d;
         rx_data_q  <= rx_data_d;
         rx_new_q   <= rx_new_d;
         rx_perr_q  <= rx_perr_d;
         rx_eerr_q  <= rx_eerr_d;
         rx_berr_q  <= rx_berr_d;
      end
   end

endmodule
